vga_rect_fill: RTL and testbench

VGA_RECT_FILL -- requirements
Module: vga_rect_fill

---
 rtl/vga_rect_fill_if.sv | 31 +++
 rtl/vga_rect_fill.sv | 115 +++++++++++
 tb/tb_vga_rect_fill.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_fill_if.sv
// MCU register bus plus framebuffer write port of the rectangle filler.
// The DONE_IRQ line exists only when VGA_FILL_IRQ_EN is defined.
interface vga_rect_fill_if;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] rd_data;
    logic [12:0] fb_wa;
    logic [7:0]  fb_wd;
    logic        fb_we;
    logic        busy;
`ifdef VGA_FILL_IRQ_EN
    logic        done_irq;
`endif

    modport master (
        output iobus_addr, iobus_out, iobus_wr,
`ifdef VGA_FILL_IRQ_EN
        input  done_irq,
`endif
        input  rd_data, fb_wa, fb_wd, fb_we, busy
    );

    modport slave (
        input  iobus_addr, iobus_out, iobus_wr,
`ifdef VGA_FILL_IRQ_EN
        output done_irq,
`endif
        output rd_data, fb_wa, fb_wd, fb_we, busy
    );
endinterface

// File: rtl/vga_rect_fill.sv
// MMIO rectangle filler: one pixel per cycle into an 80x60 framebuffer, first pixel the cycle after GO; VGA_FILL_IRQ_EN adds DONE_IRQ.
// No backpressure: the framebuffer port is owned while busy, GO during a fill is dropped.
module vga_rect_fill #(
    parameter logic [31:0] BASE_AD = 32'h11000180
) (
    input  logic           clk,
    input  logic           reset_n,
    vga_rect_fill_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [6:0]  x0, w;
    logic [5:0]  y0, h;
    logic [7:0]  color;
    logic [7:0]  col, row;
    logic [7:0]  col_first, col_last, row_last;
    logic        done;
    logic        pos_wr, size_wr, go_wr, stat_sel;
    logic        go_accept, last_pix;
    logic        unused_bits;

    assign pos_wr   = bus.iobus_wr && (bus.iobus_addr == BASE_AD);
    assign size_wr  = bus.iobus_wr && (bus.iobus_addr == BASE_AD + 32'd4);
    assign go_wr    = bus.iobus_wr && (bus.iobus_addr == BASE_AD + 32'd8);
    assign stat_sel = (bus.iobus_addr == BASE_AD + 32'd12);
    assign unused_bits = ^bus.iobus_out[31:14];

    always_comb begin
        state_nxt = state;
        go_accept = 1'b0;
        last_pix  = 1'b0;
        case (state)
            IDLE: begin
                if (go_wr && (w != 7'd0) && (h != 6'd0)) begin
                    go_accept = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if ((col == col_last) && (row == row_last)) begin
                    last_pix  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shadow registers take POS/SIZE at any time; the working copy is only loaded on an accepted GO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0        <= '0;
            y0        <= '0;
            w         <= '0;
            h         <= '0;
            color     <= '0;
            col       <= '0;
            row       <= '0;
            col_first <= '0;
            col_last  <= '0;
            row_last  <= '0;
        end else begin
            if (pos_wr) begin
                x0 <= bus.iobus_out[6:0];
                y0 <= bus.iobus_out[13:8];
            end
            if (size_wr) begin
                w <= bus.iobus_out[6:0];
                h <= bus.iobus_out[13:8];
            end
            if (go_accept) begin
                color     <= bus.iobus_out[7:0];
                col       <= {1'b0, x0};
                row       <= {2'b0, y0};
                col_first <= {1'b0, x0};
                col_last  <= {1'b0, x0} + {1'b0, w} - 8'd1;
                row_last  <= {2'b0, y0} + {2'b0, h} - 8'd1;
            end else if ((state == RUN) && !last_pix) begin
                // Counters freeze on the final pixel so FB_WA keeps its last value in IDLE.
                if (col == col_last) begin
                    col <= col_first;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       done <= 1'b0;
        else if (go_accept) done <= 1'b0;
        else if (last_pix)  done <= 1'b1;
    end

`ifdef VGA_FILL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.done_irq <= 1'b0;
        else          bus.done_irq <= last_pix;
    end
`endif

    // Outputs decode straight from registers so an async reset drops them immediately.
    assign bus.busy    = (state == RUN);
    assign bus.fb_we   = (state == RUN) && (col < 8'd80) && (row < 8'd60);
    assign bus.fb_wa   = {row[5:0], col[6:0]};
    assign bus.fb_wd   = color;
    assign bus.rd_data = stat_sel ? {30'd0, done, (state == RUN)} : 32'd0;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: directed register scenarios, then random MMIO traffic
// checked every cycle against a pixel-queue model of the fill.
module tb_vga_rect_fill;
    localparam logic [31:0] BASE = 32'h11000180;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    vga_rect_fill_if bus();

    vga_rect_fill #(.BASE_AD(BASE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int busy_cnt = 0;

    // Reference model: shadow registers plus a queue of pending pixel coordinates.
    int   m_x0, m_y0, m_w, m_h, m_color, m_last_wa;
    logic m_done, m_irq;
    int   pq_c[$];
    int   pq_r[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_color = 0;
        m_last_wa = 0; m_done = 1'b0; m_irq = 1'b0;
        pq_c.delete();
        pq_r.delete();
    endtask

    task automatic check_outputs(input logic [31:0] a);
        logic exp_busy;
        logic exp_we;
        int   c, r;
        exp_busy = (pq_c.size() != 0);
        check_eq("busy", bus.busy, exp_busy);
        if (exp_busy) begin
            c = pq_c[0];
            r = pq_r[0];
            exp_we = (c < 80) && (r < 60);
            check_eq("fb_we", bus.fb_we, exp_we);
            if (exp_we) begin
                check_eq("fb_wa", bus.fb_wa, 32'((r % 64) * 128 + (c % 128)));
                check_eq("fb_wd", bus.fb_wd, 32'(m_color));
            end
        end else begin
            check_eq("fb_we_idle", bus.fb_we, 1'b0);
            check_eq("fb_wa_hold", bus.fb_wa, 32'(m_last_wa));
        end
        check_eq("rd_data", bus.rd_data,
                 (a == BASE + 32'd12) ? {30'd0, m_done, exp_busy} : 32'd0);
`ifdef VGA_FILL_IRQ_EN
        check_eq("done_irq", bus.done_irq, m_irq);
`endif
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic wr);
        logic was_busy;
        was_busy = (pq_c.size() != 0);
        m_irq = 1'b0;
        if (was_busy) begin
            m_last_wa = (pq_r[0] % 64) * 128 + (pq_c[0] % 128);
            void'(pq_c.pop_front());
            void'(pq_r.pop_front());
            if (pq_c.size() == 0) begin
                m_done = 1'b1;
                m_irq  = 1'b1;
            end
        end
        if (wr) begin
            if (a == BASE) begin
                m_x0 = int'(d[6:0]);
                m_y0 = int'(d[13:8]);
            end else if (a == BASE + 32'd4) begin
                m_w = int'(d[6:0]);
                m_h = int'(d[13:8]);
            end else if (a == BASE + 32'd8) begin
                if (!was_busy && m_w != 0 && m_h != 0) begin
                    m_color = int'(d[7:0]);
                    m_done  = 1'b0;
                    for (int r = 0; r < m_h; r++)
                        for (int c = 0; c < m_w; c++) begin
                            pq_c.push_back(m_x0 + c);
                            pq_r.push_back(m_y0 + r);
                        end
                end
            end
        end
    endtask

    // Called at posedge+1: drive inputs, check this cycle, advance model on the edge.
    task automatic tick(input logic [31:0] a, input logic [31:0] d, input logic wr);
        bus.iobus_addr = a;
        bus.iobus_out  = d;
        bus.iobus_wr   = wr;
        #1;
        check_outputs(a);
        if (bus.fb_we === 1'b1) we_cnt++;
        if (bus.busy === 1'b1) busy_cnt++;
        @(posedge clk);
        model_edge(a, d, wr);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(BASE + 32'd12, 32'd0, 1'b0);
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        tick(BASE + off, d, 1'b1);
    endtask

    task automatic reset_mid();
        bus.iobus_wr = 1'b0;
        #1;
        check_outputs(bus.iobus_addr);
        reset_n = 1'b0;
        #1;
        check_eq("rst_fb_we", bus.fb_we, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_fb_wa", bus.fb_wa, 32'd0);
        check_eq("rst_fb_wd", bus.fb_wd, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int op;
        logic [31:0] a, d;
        bus.iobus_addr = BASE + 32'd12;
        bus.iobus_out  = 32'd0;
        bus.iobus_wr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_eq("reset_busy", bus.busy, 1'b0);
        check_eq("reset_fb_we", bus.fb_we, 1'b0);
        check_eq("reset_fb_wa", bus.fb_wa, 32'd0);
        check_eq("reset_fb_wd", bus.fb_wd, 32'd0);
        check_eq("reset_stat", bus.rd_data, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 3x2 fill at (3,2)
        wr_reg(32'd0, 32'h0000_0203);
        wr_reg(32'd4, 32'h0000_0203);
        we_cnt = 0; busy_cnt = 0;
        wr_reg(32'd8, 32'h0000_00E0);
        idle(10);
        check_eq("d3x2_we_count", we_cnt, 6);
        check_eq("d3x2_busy_count", busy_cnt, 6);

        // 4x4 at the bottom-right corner, mostly clipped
        wr_reg(32'd0, 32'h0000_3A4E);
        wr_reg(32'd4, 32'h0000_0404);
        we_cnt = 0; busy_cnt = 0;
        wr_reg(32'd8, 32'h0000_001C);
        idle(20);
        check_eq("dclip_we_count", we_cnt, 4);
        check_eq("dclip_busy_count", busy_cnt, 16);

        // zero height GO does nothing and leaves DONE set
        wr_reg(32'd4, 32'h0000_0005);
        we_cnt = 0; busy_cnt = 0;
        wr_reg(32'd8, 32'h0000_00FF);
        idle(5);
        check_eq("dzero_we_count", we_cnt, 0);
        check_eq("dzero_busy_count", busy_cnt, 0);

        // GO and SIZE written mid-fill are ignored by the running fill
        wr_reg(32'd0, 32'h0000_0A14);
        wr_reg(32'd4, 32'h0000_0404);
        we_cnt = 0; busy_cnt = 0;
        wr_reg(32'd8, 32'h0000_0055);
        idle(2);
        wr_reg(32'd8, 32'h0000_0003);
        wr_reg(32'd4, 32'h0000_0101);
        idle(16);
        check_eq("dbusy_we_count", we_cnt, 16);
        check_eq("dbusy_busy_count", busy_cnt, 16);
        #1;
        check_eq("dbusy_stat", bus.rd_data, 32'h2);

        // reset during the 5th pixel of an 8x8 fill
        wr_reg(32'd0, 32'h0000_0000);
        wr_reg(32'd4, 32'h0000_0808);
        wr_reg(32'd8, 32'h0000_0077);
        idle(4);
        reset_mid();
        we_cnt = 0;
        idle(10);
        check_eq("drst_we_count", we_cnt, 0);
        #1;
        check_eq("drst_stat", bus.rd_data, 32'h0);

        // 1x1 fill (DONE_IRQ timing covered by the per-cycle model)
        wr_reg(32'd0, 32'h0000_0101);
        wr_reg(32'd4, 32'h0000_0101);
        we_cnt = 0;
        wr_reg(32'd8, 32'h0000_0012);
        idle(4);
        check_eq("d1x1_we_count", we_cnt, 1);

        // random MMIO traffic
        for (int i = 0; i < 3000; i++) begin
            op = int'($urandom_range(0, 11));
            case (op)
                0: wr_reg(32'd0, $urandom);
                1: begin
                    d = ($urandom & 32'hFFFF_C080) | ($urandom_range(0, 10) << 8) | $urandom_range(0, 16);
                    wr_reg(32'd4, d);
                end
                2, 3: wr_reg(32'd8, $urandom);
                4: idle(1);
                5: begin
                    case ($urandom_range(0, 2))
                        0: a = BASE + 32'd16;
                        1: a = BASE - 32'd4;
                        default: a = $urandom;
                    endcase
                    tick(a, $urandom, 1'b1);
                end
                6: tick($urandom, $urandom, 1'b0);
                default: idle(int'($urandom_range(1, 8)));
            endcase
            if (i == 1500) reset_mid();
        end
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
